inv_key_expansion: RTL and testbench
====================================

INV_KEY_EXPANSION -- requirements
Module: inv_key_expansion

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-003 SHALL have port start, input, 1, request to expand last_key backward; sampled only in IDLE.
REQ-004 SHALL have port last_key, input, 128, AES-128 round-10 key; word w40 = [127:96] ... w43 = [31:0].
REQ-005 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-006 SHALL have port key_valid, output, 1, round_key/round_idx are valid.
REQ-007 SHALL have port key_ready, input, 1, consumer accepts the key when key_valid && key_ready.
REQ-008 SHALL have port round_key, output, 128, current round key; same word order as last_key.
REQ-009 SHALL have port round_idx, output, 4, round number of round_key, 10 down to 0.
REQ-010 SHALL have port done, output, 1, one-cycle pulse after round 0 is accepted.

Function
REQ-011 SHALL implement states IDLE, EMIT and FIN.
- IDLE -> EMIT on start: latch last_key, round_idx=10, rcon=8'h36.
REQ-012 SHALL assert key_valid one cycle after start is sampled; start-to-first-key latency is 1 cycle.
REQ-013 SHALL hold round_key, round_idx and key_valid stable in EMIT while key_ready is low.
REQ-014 On handshake with round_idx>0, the block SHALL go to the previous round key in one cycle (key_valid stays high).
- With current words w0..w3: p3=w3^w2; p2=w2^w1; p1=w1^w0.
- p0 = w0 ^ SubWord(RotWord(p3)) ^ {rcon,24'h0}.
- RotWord is a left rotate by 8; SubWord is 4 instances of the team's forward S-box.
REQ-015 On each such handshake, the block SHALL update rcon by inverse xtime: rcon[0] ? ((rcon^9'h11b)>>1) : rcon>>1.
- Sequence: 36,1b,80,40,20,10,08,04,02,01.
REQ-016 On handshake with round_idx==0, the block SHALL move to FIN and deassert key_valid.
REQ-017 In FIN, the block SHALL assert done for exactly one cycle, then return to IDLE.
REQ-018 The block SHALL ignore start while busy; last_key changes after the IDLE capture SHALL have no effect.
REQ-019 Exactly 11 keys SHALL be emitted per start, in order 10..0, with no duplicates or skips.
REQ-020 start asserted in the FIN cycle SHALL be ignored; start is honoured from IDLE only.

Reset
REQ-021 On rst_n low, the block SHALL immediately enter IDLE, regardless of clk or state.
- Reset values: key_valid=0, done=0, busy=0, round_key=0, round_idx=0, rcon=8'h36.
REQ-022 Reset mid-sequence SHALL abandon the sequence; no done pulse; the next start begins again at round 10.
REQ-023 Reset deassertion SHALL produce no output activity until start.

Configuration
REQ-024 The feature SHALL be controlled by macro AES_INVKEY_EQINV_EN.
- Defined: for round_idx 9..1, round_key outputs InvMixColumns(key), per column, for the equivalent inverse cipher.
- Defined: rounds 10 and 0 are output untransformed.
- Internal recursion always uses the untransformed key.
- Undefined: round_key is always the plain round key, and no InvMixColumns logic is present.

Verification
REQ-025 Scenario: FIPS-197 vector, last_key=d014f9a8c9ee2589e13f0cc8b6630ca6, key_ready=1.
- Keys emitted on consecutive cycles.
- Round 9 = ac7766f319fadc2128d12941575c006e.
- Round 1 = a0fafe1788542cb123a339392a6c7605.
- Round 0 = 2b7e151628aed2a6abf7158809cf4f3c.
- done is asserted 1 cycle after round 0.
REQ-026 Scenario: same vector with key_ready toggling randomly.
- Identical 11-key sequence.
- Outputs are stable while key_ready is low.
REQ-027 Scenario: start pulsed at round_idx=5 with a different last_key.
- Sequence is unaffected.
- No restart.
REQ-028 Scenario: rst_n low while round_idx=4.
- All outputs are reset values immediately.
- A fresh start emits round 10 = new last_key.
REQ-029 Scenario: AES_INVKEY_EQINV_EN defined, FIPS vector.
- Round 10 and round 0 are unchanged.
- Rounds 9..1 equal InvMixColumns of the REQ-025 keys.
REQ-030 Scenario: back-to-back operation, start asserted in the cycle after done.
- A second full sequence starts with key_valid 1 cycle later.

Source files
------------

// File: rtl/inv_key_expansion.sv
// ============================================================================
// Module   : inv_key_expansion
// Purpose  : Walks the AES-128 key schedule backward from the round-10 key,
//            presenting round keys 10..0 over a valid/ready handshake.
//            `AES_INVKEY_EQINV_EN: rounds 9..1 are output through
//            InvMixColumns for the equivalent inverse cipher.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inv_key_expansion (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] last_key,
    output logic         busy,
    output logic         key_valid,
    input  logic         key_ready,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         done
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_EMIT = 2'd1;
    localparam logic [1:0] c_FIN  = 2'd2;

    localparam logic [7:0] c_RCON_LAST = 8'h36;

    // Forward S-box, byte 0x00 in the most significant position
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        sbox = c_SBOX[{~b, 3'd0} +: 8];
    endfunction

    logic [1:0]   r_state;
    logic [127:0] r_key;
    logic [3:0]   r_idx;
    logic [7:0]   r_rcon;

    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [31:0]  w_p0, w_p1, w_p2, w_p3;
    logic [31:0]  w_rot;
    logic [7:0]   w_rcon_next;
    logic         w_handshake;

    assign w_w0 = r_key[127:96];
    assign w_w1 = r_key[95:64];
    assign w_w2 = r_key[63:32];
    assign w_w3 = r_key[31:0];

    assign w_p3  = w_w3 ^ w_w2;
    assign w_p2  = w_w2 ^ w_w1;
    assign w_p1  = w_w1 ^ w_w0;
    assign w_rot = {w_p3[23:0], w_p3[31:24]};
    assign w_p0  = w_w0 ^ {sbox(w_rot[31:24]), sbox(w_rot[23:16]),
                           sbox(w_rot[15:8]),  sbox(w_rot[7:0])}
                        ^ {r_rcon, 24'h0};

    // Division by x in GF(2^8): odd values fold the reduction polynomial back in
    assign w_rcon_next = r_rcon[0] ? (((r_rcon ^ 8'h1b) >> 1) | 8'h80)
                                   : (r_rcon >> 1);

    assign w_handshake = (r_state == c_EMIT) && key_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_key   <= '0;
            r_idx   <= '0;
            r_rcon  <= c_RCON_LAST;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_state <= c_EMIT;
                        r_key   <= last_key;
                        r_idx   <= 4'd10;
                        r_rcon  <= c_RCON_LAST;
                    end
                end
                c_EMIT: begin
                    if (w_handshake) begin
                        if (r_idx == 4'd0) begin
                            r_state <= c_FIN;
                        end else begin
                            r_key  <= {w_p0, w_p1, w_p2, w_p3};
                            r_idx  <= r_idx - 4'd1;
                            r_rcon <= w_rcon_next;
                        end
                    end
                end
                c_FIN:   r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign busy      = (r_state != c_IDLE);
    assign key_valid = (r_state == c_EMIT);
    assign done      = (r_state == c_FIN);
    assign round_idx = r_idx;

`ifdef AES_INVKEY_EQINV_EN
    function automatic logic [7:0] xt(input logic [7:0] b);
        xt = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant; the bits select x^3..x^0 partial products
    function automatic logic [7:0] mulc(input logic [7:0] b, input logic [3:0] c);
        logic [7:0] x2, x4, x8;
        x2 = xt(b);
        x4 = xt(x2);
        x8 = xt(x4);
        mulc = (c[3] ? x8 : 8'h00) ^ (c[2] ? x4 : 8'h00) ^
               (c[1] ? x2 : 8'h00) ^ (c[0] ? b  : 8'h00);
    endfunction

    logic [127:0] w_imc;

    for (genvar g = 0; g < 4; g++) begin : g_imc_col
        logic [7:0] a0, a1, a2, a3;
        assign a0 = r_key[127-32*g -: 8];
        assign a1 = r_key[119-32*g -: 8];
        assign a2 = r_key[111-32*g -: 8];
        assign a3 = r_key[103-32*g -: 8];
        assign w_imc[127-32*g -: 8] = mulc(a0, 4'he) ^ mulc(a1, 4'hb) ^ mulc(a2, 4'hd) ^ mulc(a3, 4'h9);
        assign w_imc[119-32*g -: 8] = mulc(a0, 4'h9) ^ mulc(a1, 4'he) ^ mulc(a2, 4'hb) ^ mulc(a3, 4'hd);
        assign w_imc[111-32*g -: 8] = mulc(a0, 4'hd) ^ mulc(a1, 4'h9) ^ mulc(a2, 4'he) ^ mulc(a3, 4'hb);
        assign w_imc[103-32*g -: 8] = mulc(a0, 4'hb) ^ mulc(a1, 4'hd) ^ mulc(a2, 4'h9) ^ mulc(a3, 4'he);
    end

    assign round_key = ((r_idx != 4'd0) && (r_idx != 4'd10)) ? w_imc : r_key;
`else
    assign round_key = r_key;
`endif

endmodule

`default_nettype wire

// File: tb/tb_inv_key_expansion.sv
// ============================================================================
// Module   : tb_inv_key_expansion
// Purpose  : Scoreboard bench for inv_key_expansion against a forward-schedule
//            reference model run in reverse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inv_key_expansion;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] last_key;
    logic         busy;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         done;

    always #5 clk = ~clk;

    inv_key_expansion dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .last_key  (last_key),
        .busy      (busy),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .round_key (round_key),
        .round_idx (round_idx),
        .done      (done)
    );

    localparam logic [127:0] c_FIPS_LAST = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] c_FIPS_R9   = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] c_FIPS_R1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] c_FIPS_R0   = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [7:0]   sbox_t [256];
    logic [7:0]   rc_t [11];
    logic [127:0] exp_keys [11];
    logic [131:0] sb_q [$];
    bit           exp_done   = 1'b0;
    bit           hold_pend  = 1'b0;
    logic [132:0] held;
    bit           ready_rand = 1'b0;

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rol8(input logic [7:0] b, input int n);
        logic [15:0] d = {b, b};
        return d[15-n -: 8];
    endfunction

    // S-box derived from its definition: multiplicative inverse then affine map
    function automatic void build_tables();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
        end
        rc_t[0] = 8'h00;
        rc_t[1] = 8'h01;
        for (int j = 2; j < 11; j++) rc_t[j] = gmul(rc_t[j-1], 8'h02);
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    // Undo the FIPS-197 recurrence w[i] = w[i-4] ^ T(w[i-1]) from the top down
    function automatic void expand_back(input logic [127:0] lk);
        logic [31:0] w [44];
        logic [31:0] t;
        w[40] = lk[127:96]; w[41] = lk[95:64]; w[42] = lk[63:32]; w[43] = lk[31:0];
        for (int i = 43; i >= 4; i--) begin
            t = w[i-1];
            if (i % 4 == 0) t = subw({t[23:0], t[31:24]}) ^ {rc_t[i/4], 24'h0};
            w[i-4] = w[i] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] k);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = k[127-32*c -: 8]; a1 = k[119-32*c -: 8];
            a2 = k[111-32*c -: 8]; a3 = k[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return o;
    endfunction

    function automatic logic [127:0] present(input int r, input logic [127:0] k);
`ifdef AES_INVKEY_EQINV_EN
        if (r >= 1 && r <= 9) return inv_mix(k);
`endif
        return k;
    endfunction

    always @(posedge clk) begin
        #1;
        key_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: done pulse, hold-while-stalled, and in-order key delivery
    always @(negedge clk) begin
        logic [131:0] item;
        if (rst_n === 1'b1) begin
            check("done_pulse", 136'(done), 136'(exp_done));
            exp_done = 1'b0;
            if (hold_pend)
                check("stall_hold", 136'({key_valid, round_idx, round_key}), 136'(held));
            if (key_valid && key_ready) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_key: got round %0d, expected no key", round_idx);
                end else begin
                    item = sb_q.pop_front();
                    check("round_key", 136'({round_idx, round_key}), 136'(item));
                    if (item[131:128] == 4'd0) exp_done = 1'b1;
                end
                hold_pend = 1'b0;
            end else if (key_valid) begin
                hold_pend = 1'b1;
                held      = {1'b1, round_idx, round_key};
            end else begin
                hold_pend = 1'b0;
            end
        end
    end

    task automatic run_seq(input logic [127:0] key, input bit fips, input int poke_idx,
                           input int abort_idx, input int exp_cyc);
        int           cyc   = 0;
        bit           poked = 1'b0;
        logic [127:0] e;
        expand_back(key);
        @(posedge clk);
        #1;
        last_key = key;
        start    = 1'b1;
        for (int r = 10; r >= 0; r--) begin
            e = exp_keys[r];
            if (fips && r == 9) e = c_FIPS_R9;
            if (fips && r == 1) e = c_FIPS_R1;
            if (fips && r == 0) e = c_FIPS_R0;
            sb_q.push_back({4'(r), present(r, e)});
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check("first_key_latency", 136'({busy, key_valid}), 136'(2'b11));
            last_key = {$urandom, $urandom, $urandom, $urandom};
            if (start) start = 1'b0;
            if (poke_idx >= 0 && !poked && key_valid && round_idx == 4'(poke_idx)) begin
                start = 1'b1;
                poked = 1'b1;
            end
            if (abort_idx >= 0 && key_valid && round_idx == 4'(abort_idx)) begin
                #2 rst_n = 1'b0;
                #1 check("async_reset_outputs",
                         136'({busy, key_valid, done, round_idx, round_key}), 136'(0));
                sb_q.delete();
                exp_done  = 1'b0;
                hold_pend = 1'b0;
                return;
            end
            if (done) break;
            if (cyc > 200) begin
                n_tests++;
                n_fail++;
                $display("FAIL done_timeout: got no done after %0d cycles, expected done", cyc);
                break;
            end
        end
        if (exp_cyc > 0) check("cycles_to_done", 136'(cyc), 136'(exp_cyc));
        check("queue_drained", 136'(sb_q.size()), 136'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        last_key  = '0;
        key_ready = 1'b1;
        build_tables();
        #12;
        check("reset_values", 136'({busy, key_valid, done, round_idx, round_key}), 136'(0));
        #11 rst_n = 1'b1;

        // FIPS vector, always ready: 11 keys on consecutive cycles
        run_seq(c_FIPS_LAST, 1'b1, -1, -1, 12);
        // Started in the cycle after done, with a stalling consumer
        ready_rand = 1'b1;
        run_seq(c_FIPS_LAST, 1'b1, -1, -1, 0);
        for (int n = 0; n < 4; n++)
            run_seq({$urandom, $urandom, $urandom, $urandom}, 1'b0, -1, -1, 0);
        ready_rand = 1'b0;

        // start re-pulsed mid-sequence is ignored
        run_seq({$urandom, $urandom, $urandom, $urandom}, 1'b0, 5, -1, 12);

        // start during FIN is ignored
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("fin_start_ignored", 136'({busy, key_valid, done}), 136'(0));
        end

        // Asynchronous reset at round 4, then a fresh sequence
        run_seq({$urandom, $urandom, $urandom, $urandom}, 1'b0, -1, 4, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            check("idle_after_reset", 136'({busy, key_valid, done}), 136'(0));
        end
        run_seq({$urandom, $urandom, $urandom, $urandom}, 1'b0, -1, -1, 12);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
